// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared types and saturating add for the noise injector
// Contents: DATA_W_DEFAULT (default sample width), state_t {FILL, RUN},
// sat_add (signed add clamped to a w-bit two's complement range, w <= 30).
package noise_pkg;

  localparam int DATA_W_DEFAULT = 16;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Operands arrive sign-extended to 32 bits, so the 32-bit sum cannot wrap
  // for any w up to 30; the clamp then folds it back into w bits.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int w);
    logic signed [31:0] s;
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    s  = a + b;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -(32'sd1 <<< (w - 1));
    if (s > hi) return hi;
    if (s < lo) return lo;
    return s;
  endfunction

endpackage

// File: rtl/noise_fifo.sv
// rtl/noise_fifo.sv - synchronous FIFO buffering generator noise samples
// Ports: clk, rst (sync, active high); push/push_data write side; pop/head
// read side (head is the stored oldest entry, no fall-through); count, full,
// empty status from registered state. A push while full is taken only if a
// pop happens in the same cycle; a pop while empty is ignored.
module noise_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage has no reset so it can map onto plain RAM/flops without a reset net.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/noise_injector.sv
// rtl/noise_injector.sv - adds scaled, saturated Gaussian noise to a data stream
// Optional feature macro: NOISE_INJ_BYPASS_EN (adds input bypass).
// Ports: clk, rst (sync, active high); noise_in/noise_valid from the generator,
// noise_req back to it (high while the FIFO has room); in_data/in_valid/
// in_ready input stream; out_data/out_valid/out_ready output stream;
// noise_ovf sticky flag for a sample dropped on a full FIFO.
module noise_injector
  import noise_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEFAULT,
  parameter int FIFO_DEPTH  = 8,
  parameter int PRIME_LVL   = 4,
  parameter int NOISE_SHIFT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] noise_in,
  input  logic              noise_valid,
  output logic              noise_req,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              noise_ovf
`ifdef NOISE_INJ_BYPASS_EN
  ,
  input  logic              bypass
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t             state;
  logic [DATA_W-1:0]  head;
  logic [CW-1:0]      count;
  logic               full;
  logic               empty;
  logic               out_free;
  logic               accept;
  logic               pop;
  logic               drop;
  logic signed [31:0] data_ext;
  logic signed [31:0] noise_ext;
  logic signed [31:0] sum_sat;
  logic [DATA_W-1:0]  noisy;
  logic [DATA_W-1:0]  result;
  logic               sat_unused;

  noise_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (noise_valid),
    .push_data (noise_in),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign noise_req = !full;
  assign out_free  = !out_valid || out_ready;
  assign accept    = in_valid && in_ready;
  // A full FIFO still takes a sample when the same cycle frees an entry.
  assign drop      = noise_valid && full && !pop;

  assign data_ext  = 32'($signed(in_data));
  assign noise_ext = 32'($signed(head) >>> NOISE_SHIFT);
  assign sum_sat   = sat_add(data_ext, noise_ext, DATA_W);
  assign noisy     = sum_sat[DATA_W-1:0];
  // Upper bits are pure sign copies after the clamp.
  assign sat_unused = ^sum_sat[31:DATA_W];

`ifdef NOISE_INJ_BYPASS_EN
  assign in_ready = (state == RUN) && out_free && (bypass || !empty);
  assign pop      = accept && !bypass;
  assign result   = bypass ? in_data : noisy;
`else
  assign in_ready = (state == RUN) && out_free && !empty;
  assign pop      = accept;
  assign result   = noisy;
`endif

  // FILL is left once, on registered occupancy; an empty FIFO later only stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      out_data  <= '0;
      out_valid <= 1'b0;
      noise_ovf <= 1'b0;
    end else begin
      case (state)
        FILL:    if (count >= CW'(PRIME_LVL)) state <= RUN;
        RUN:     state <= RUN;
        default: state <= FILL;
      endcase

      if (accept) begin
        out_data  <= result;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (drop) noise_ovf <= 1'b1;
    end
  end

endmodule

// File: doc/noise_injector.md
Name: noise_injector

Overview:
- Downstream consumer of the Gaussian noise generator. Buffers the generator's 16-bit noise samples in a small FIFO.
- Adds one scaled noise sample to each word of a valid/ready data stream, with saturation.
- Drives the generator's enable input so that noise is produced only when there is buffer space.
- Sits between the noise source and the protected datapath (e.g. activation or weight stream).

Parameters:
- DATA_W, 16, width of data stream and noise samples (signed two's complement).
- FIFO_DEPTH, 8, noise FIFO entries; must be a power of 2, minimum 2.
- PRIME_LVL, 4, FIFO occupancy required before the first data word is accepted after reset; 1 <= PRIME_LVL <= FIFO_DEPTH.
- NOISE_SHIFT, 4, arithmetic right shift applied to noise before the add.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- noise_in  in  DATA_W  noise sample from the generator.
- noise_valid  in  1  noise_in is valid this cycle.
- noise_req  out  1  enable to the generator; high when the FIFO is not full.
- in_data  in  DATA_W  signed data word.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- out_data  out  DATA_W  noisy signed result.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- noise_ovf  out  1  sticky: a noise sample was dropped because the FIFO was full.

Behaviour:
- Reset (rst=1 at a clock edge):
  - FIFO count and pointers = 0.
  - State = FILL.
  - out_valid = 0, out_data = 0, noise_ovf = 0.
  - noise_req reads 1 in the cycle after reset, since the FIFO is empty.
  - Reset mid-transfer discards the FIFO contents and the output register.
- Push:
  - A sample is pushed when noise_valid=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle).
  - Otherwise the sample is dropped and noise_ovf is set; it stays set until reset.
- noise_req = (count != FIFO_DEPTH). This is combinational from registered count.
- State machine:
  - FILL: in_ready=0. Go to RUN when count >= PRIME_LVL, evaluated on registered count.
  - RUN: in_ready = (count != 0) && (!out_valid || out_ready).
    - An empty FIFO stalls input but the state stays RUN; there is no re-priming.
    - Only reset returns the machine to FILL.
- Accept (in_valid && in_ready):
  - Pop the FIFO head as n.
  - Compute scaled = n >>> NOISE_SHIFT (arithmetic shift).
  - Compute sum = sign-extended in_data + scaled, with DATA_W+1 bits.
  - Saturate sum to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - Register the result into out_data and set out_valid=1 on the next edge. Latency is 1 cycle.
- Output handshake:
  - out_valid clears when out_ready=1 and no new accept occurs in that cycle.
  - out_data is held stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop:
  - Count is unchanged.
  - When full, a push with a simultaneous pop is legal and not dropped.
  - When empty, a push lands in the FIFO but cannot be popped in that same cycle; there is no fall-through.
- Pointers wrap modulo FIFO_DEPTH. Count has log2(FIFO_DEPTH)+1 bits.

Optional Feature:
- Macro: NOISE_INJ_BYPASS_EN.
- When defined:
  - Adds input port bypass (1 bit).
  - In RUN with bypass=1: in_ready = (!out_valid || out_ready), independent of FIFO count.
  - out_data = in_data unmodified and the FIFO is not popped.
  - FILL still blocks input.
- When undefined: no port is added, and every accepted word consumes one noise sample.

Decomposition:
- Shared package noise_pkg holds:
  - DATA_W default.
  - State enum {FILL, RUN}.
  - Saturating add function sat_add.
- Natural sub-module: noise_fifo (synchronous FIFO with push, pop, count, full and empty; registered outputs, no fall-through).
- The FSM and the add/saturate stage stay in noise_injector.

Test Plan:
- Prime: reset, then push 4 samples of 0x0010 with in_valid=1 held → in_ready stays 0 until count=4 is registered. The first accepted in_data=0x0100 gives out_data=0x0101 one cycle later.
- Saturation: noise 0x7FF0 (scaled 0x07FF) with in_data 0x7F00 → out_data=0x7FFF. Noise 0x8000 (scaled 0xF800) with in_data 0x8100 → out_data=0x8000.
- Backpressure: out_ready=0 for 5 cycles → out_data held, in_ready=0, exactly one FIFO pop. Release → stream resumes with no loss or duplication.
- Overflow: fill 8 samples with no data traffic → noise_req=0. A further noise_valid → noise_ovf=1, count stays 8. Push and accept in the same cycle while full → no drop, count stays 8.
- Starvation: in RUN, drain the FIFO to 0 → in_ready=0 and state stays RUN. One push → in_ready=1 on the next cycle.
- Reset mid-stream: assert rst with out_valid=1 and count=5 → next cycle out_valid=0, count=0, state FILL, noise_ovf=0.
